// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_sched_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} sched_state_t;
  localparam int DIGITS = 4;
endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester/display-side bundle: master = producers, slave = scheduler.
interface seg_display_scheduler_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0]    REQ;
  logic [16*N_REQ-1:0] DATA;
  logic [N_REQ-1:0]    ACK;
  logic [15:0]         HEX;
  logic                LOAD;
  logic                MUX_CLK;
  logic                BUSY;

  modport master (output REQ, DATA, input ACK, HEX, LOAD, MUX_CLK, BUSY);
  modport slave  (input REQ, DATA, output ACK, HEX, LOAD, MUX_CLK, BUSY);
endinterface

// File: rtl/mux_clk_divider.sv
// Free-running digit-scan clock divider; frame_tick pulses once per 4-digit scan.
module mux_clk_divider
  import seg_sched_pkg::*;
#(
  parameter int MUX_DIV = 50000
) (
  input  logic CLK,
  input  logic RESET,
  output logic MUX_CLK,
  output logic frame_tick
);
  localparam int CW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam logic [CW-1:0] TC    = CW'(MUX_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] digit;
  logic          tc;
  logic          rise;

  assign tc   = (cnt == TC);
  assign rise = tc && !MUX_CLK;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt        <= '0;
      MUX_CLK    <= 1'b0;
      digit      <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc)   MUX_CLK <= ~MUX_CLK;
      if (rise) digit   <= digit + 1'b1;
      // registered so the tick lines up with the scan restarting on digit 0
      frame_tick <= rise && (digit == DLAST);
    end
  end
endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing one multiplexed 7-seg display among N_REQ producers.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int MUX_DIV     = 50000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  seg_display_scheduler_if.slave  bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int FW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [FW-1:0] FLAST = FW'(HOLD_FRAMES);
  localparam logic [PW-1:0] PLAST = PW'(N_REQ - 1);

  sched_state_t  state, state_nxt;
  logic [PW-1:0] ptr, winner, pick, cand;
  logic          found;
  logic [FW-1:0] fcnt;
  logic [15:0]   hex, data_sel;
  logic [N_REQ-1:0] ack;
  logic          frame_tick;

  mux_clk_divider #(.MUX_DIV(MUX_DIV)) u_div (
    .CLK        (CLK),
    .RESET      (RESET),
    .MUX_CLK    (bus.MUX_CLK),
    .frame_tick (frame_tick)
  );

  // first requester after the last winner, wrapping at N_REQ
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == PLAST) ? '0 : cand + 1'b1;
      if (!found && bus.REQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (PW'(i) == pick) data_sel = bus.DATA[16*i +: 16];
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    case (state)
      IDLE:    if (found) state_nxt = SETUP;
      SETUP: begin
        ack[winner] = 1'b1;
        state_nxt   = STROBE;
      end
      STROBE:  state_nxt = (HOLD_FRAMES == 0) ? IDLE : HOLD;
      HOLD:    if (fcnt == FLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      ptr    <= PLAST;
      winner <= '0;
      hex    <= '0;
      fcnt   <= '0;
    end else begin
      state <= state_nxt;
      // HEX is captured with the grant so it is valid through the ACK cycle
      if (state == IDLE && found) begin
        winner <= pick;
        hex    <= data_sel;
      end
      if (state == SETUP) ptr <= winner;
      if (state == STROBE)
        fcnt <= '0;
      else if (state == HOLD && frame_tick && fcnt != FLAST)
        fcnt <= fcnt + 1'b1;
    end
  end

  assign bus.ACK  = ack;
  assign bus.HEX  = hex;
  assign bus.LOAD = (state == STROBE);
  assign bus.BUSY = (state != IDLE);
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench: two schedulers (HOLD_FRAMES=1 and 0) checked each cycle against a grant-timeline model.
module tb_seg_display_scheduler;
  localparam int N  = 2;
  localparam int MD = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic [N-1:0] req_v [2];
  logic [15:0]  dat [2][N];

  seg_display_scheduler_if #(.N_REQ(N)) bus0 ();
  seg_display_scheduler_if #(.N_REQ(N)) bus1 ();

  assign bus0.REQ  = req_v[0];
  assign bus1.REQ  = req_v[1];
  assign bus0.DATA = {dat[0][1], dat[0][0]};
  assign bus1.DATA = {dat[1][1], dat[1][0]};

  seg_display_scheduler #(.N_REQ(N), .MUX_DIV(MD), .HOLD_FRAMES(1)) u0 (
    .CLK(CLK), .RESET(RESET), .bus(bus0.slave));
  seg_display_scheduler #(.N_REQ(N), .MUX_DIV(MD), .HOLD_FRAMES(0)) u1 (
    .CLK(CLK), .RESET(RESET), .bus(bus1.slave));

  logic [N-1:0] ack_o [2];
  logic [15:0]  hex_o [2];
  logic         load_o [2], busy_o [2], mclk_o [2];
  assign ack_o[0]  = bus0.ACK;     assign ack_o[1]  = bus1.ACK;
  assign hex_o[0]  = bus0.HEX;     assign hex_o[1]  = bus1.HEX;
  assign load_o[0] = bus0.LOAD;    assign load_o[1] = bus1.LOAD;
  assign busy_o[0] = bus0.BUSY;    assign busy_o[1] = bus1.BUSY;
  assign mclk_o[0] = bus0.MUX_CLK; assign mclk_o[1] = bus1.MUX_CLK;

  always #5 CLK = ~CLK;

  // model: e = rising edges since reset release; per DUT the last grant edge g,
  // the edge endv after which the FSM is idle again, and the first edge free to grant
  int e;
  int hf [2];
  int ptr [2], g [2], endv [2], free_e [2], win [2];
  logic [15:0] mhex [2];
  int compared = 0, mismatched = 0;
  int mode;  // 0: drop REQ on ACK, 1: hold REQ, 2: random requester behaviour

  function automatic bit is_tick(input int m);
    return (m % MD == 0) && ((m / MD) % 8 == 7);
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // idle after the edge that follows the cycle in which the H-th counted frame completes
  function automatic int hold_end(input int gr, input int h);
    int n;
    if (h == 0) return gr + 2;
    n = 0;
    for (int m = gr + 2; m < gr + 10000; m++)
      if (is_tick(m)) begin
        n++;
        if (n == h) return m + 2;
      end
    return gr + 10000;
  endfunction

  task automatic model_reset();
    e = 0;
    for (int d = 0; d < 2; d++) begin
      ptr[d] = N - 1; g[d] = -1; endv[d] = 0; free_e[d] = 1; win[d] = 0; mhex[d] = 16'h0000;
    end
  endtask

  task automatic model_edge();
    int w;
    e++;
    for (int d = 0; d < 2; d++)
      if (e >= free_e[d] && req_v[d] != '0) begin
        w = rr(req_v[d], ptr[d]);
        win[d] = w; ptr[d] = w; g[d] = e;
        mhex[d] = dat[d][w];
        endv[d] = hold_end(e, hf[d]);
        free_e[d] = endv[d] + 1;
      end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d edge=%0d: observed %0h expected %0h", tag, d, e, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] xa;
    for (int d = 0; d < 2; d++) begin
      xa = '0;
      if (g[d] == e) xa[win[d]] = 1'b1;
      chk("ack",  d, 32'(ack_o[d]),  32'(xa));
      chk("load", d, 32'(load_o[d]), 32'(g[d] >= 0 && e == g[d] + 1));
      chk("busy", d, 32'(busy_o[d]), 32'(g[d] >= 0 && e >= g[d] && e < endv[d]));
      chk("hex",  d, 32'(hex_o[d]),  32'(mhex[d]));
      chk("mux_clk", d, 32'(mclk_o[d]), 32'((e / MD) % 2));
    end
  endtask

  task automatic drive();
    bit acked;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        acked = (g[d] == e) && (win[d] == i);
        if (mode == 0) begin
          if (acked) req_v[d][i] = 1'b0;
        end else if (mode == 2) begin
          if (acked) begin
            if ($urandom_range(1) == 0) req_v[d][i] = 1'b0;
            dat[d][i] = 16'($urandom);
          end else if (!req_v[d][i]) begin
            if ($urandom_range(9) < 3) begin
              req_v[d][i] = 1'b1;
              dat[d][i]   = 16'($urandom);
            end
          end else if ($urandom_range(19) == 0) begin
            req_v[d][i] = 1'b0;
          end
        end
      end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
    drive();
  endtask

  // step until a new grant on dut0 is k edges old; a missed bound counts as a failure
  task automatic wait_grant0(input int k);
    int gp;
    bit ok;
    gp = g[0];
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      ok = (g[0] != gp) && (e == g[0] + k);
    end
    chk("grant_timeout", 0, 32'(ok), 32'd1);
  endtask

  initial begin
    int cnt;
    hf[0] = 1; hf[1] = 0;
    mode = 0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0;
      for (int i = 0; i < N; i++) dat[d][i] = 16'h0000;
    end
    model_reset();
    @(negedge CLK);
    check_all();
    RESET = 1'b1;

    // idle: divider runs, nothing else moves
    repeat (6) step();

    // single request from requester 0
    req_v[0] = 2'b01; req_v[1] = 2'b01;
    dat[0][0] = 16'h1234; dat[1][0] = 16'h1234;
    repeat (24) step();

    // both requesting continuously: alternate grants
    mode = 1;
    for (int d = 0; d < 2; d++) begin
      dat[d][0] = 16'hAAAA; dat[d][1] = 16'h5555; req_v[d] = 2'b11;
    end
    repeat (70) step();
    req_v[0] = '0; req_v[1] = '0;
    mode = 0;
    repeat (20) step();

    // requester 1 pulses during HOLD and withdraws before IDLE
    dat[0][0] = 16'hC0DE; dat[0][1] = 16'hBEEF;
    req_v[0] = 2'b01;
    wait_grant0(2);
    req_v[0][1] = 1'b1;
    for (int n = 0; n < 100 && e + 1 < endv[0]; n++) step();
    req_v[0][1] = 1'b0;
    repeat (20) step();

    // reset in STROBE drops everything at once and restores the pointer
    req_v[0] = 2'b01;
    wait_grant0(1);
    RESET = 1'b0;
    model_reset();
    #1;
    check_all();
    req_v[0] = '0; req_v[1] = '0;
    @(negedge CLK);
    req_v[0] = 2'b11; req_v[1] = 2'b10;
    dat[0][0] = 16'h0F0F; dat[0][1] = 16'hF0F0;
    dat[1][0] = 16'h1111; dat[1][1] = 16'h2222;
    RESET = 1'b1;
    repeat (20) step();

    // zero hold frames: LOAD every 3 cycles while REQ held
    mode = 1;
    req_v[0] = '0; req_v[1] = 2'b01;
    repeat (4) step();
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (load_o[1] === 1'b1) cnt++;
    end
    chk("load_rate", 1, 32'(cnt), 32'd4);
    req_v[1] = '0;
    mode = 0;
    repeat (10) step();

    // randomized requester traffic
    mode = 2;
    repeat (600) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
